// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage feeding the write-back select mux; waits on variable-latency load data.
// Optional WB_LOAD_EXT_EN adds sub-word load selection with sign/zero extension.
module mem_wb_stage #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_reg_write,
    input  logic              in_mem_to_reg,
`ifdef WB_LOAD_EXT_EN
    input  logic [1:0]        in_mem_size,
    input  logic              in_mem_unsigned,
    input  logic [1:0]        in_addr_lo,
`endif
    input  logic              flush,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rdata_valid,
    output logic              stall_up,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_alu_result,
    output logic [DATA_W-1:0] wb_mem_data,
    output logic              wb_mem_to_reg,
    output logic [REG_AW-1:0] wb_rd,
    output logic              wb_reg_write,
    output logic              err_timeout
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] p_alu_q, p_alu_d;
    logic [REG_AW-1:0] p_rd_q, p_rd_d;
    logic              p_rw_q, p_rw_d;
    logic              wb_valid_q, wb_valid_d;
    logic [DATA_W-1:0] wb_alu_q, wb_alu_d;
    logic [DATA_W-1:0] wb_mem_q, wb_mem_d;
    logic              wb_m2r_q, wb_m2r_d;
    logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
    logic              wb_rw_q, wb_rw_d;
    logic              err_q, err_d;

    logic              in_idle, load_done, ld_rw, ld_kill;
    logic [DATA_W-1:0] ld_alu, ld_data;
    logic [REG_AW-1:0] ld_rd;

`ifdef WB_LOAD_EXT_EN
    logic [1:0] p_size_q, p_size_d, p_lo_q, p_lo_d, ld_size, ld_lo;
    logic       p_uns_q, p_uns_d, ld_uns;

    function automatic logic [DATA_W-1:0] load_ext(input logic [DATA_W-1:0] w,
                                                   input logic [1:0] size,
                                                   input logic uns,
                                                   input logic [1:0] lo);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{lo, 3'b000} +: 8];
        h = w[{lo[1], 4'b0000} +: 16];
        case (size)
            2'd0:    return {{(DATA_W-8){b[7] & ~uns}}, b};
            2'd1:    return {{(DATA_W-16){h[15] & ~uns}}, h};
            default: return w;
        endcase
    endfunction
`endif

    // A load completing in IDLE takes its fields straight from the inputs, otherwise from the pending copy.
    always_comb begin
        in_idle = (state_q == IDLE);
        ld_alu  = in_idle ? in_alu_result : p_alu_q;
        ld_rd   = in_idle ? in_rd : p_rd_q;
        ld_rw   = in_idle ? in_reg_write : p_rw_q;
`ifdef WB_LOAD_EXT_EN
        ld_size = in_idle ? in_mem_size : p_size_q;
        ld_uns  = in_idle ? in_mem_unsigned : p_uns_q;
        ld_lo   = in_idle ? in_addr_lo : p_lo_q;
        ld_data = load_ext(mem_rdata, ld_size, ld_uns, ld_lo);
        ld_kill = (ld_size == 2'd1) && ld_lo[0];
`else
        ld_data = mem_rdata;
        ld_kill = 1'b0;
`endif
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        p_alu_d    = p_alu_q;
        p_rd_d     = p_rd_q;
        p_rw_d     = p_rw_q;
`ifdef WB_LOAD_EXT_EN
        p_size_d   = p_size_q;
        p_uns_d    = p_uns_q;
        p_lo_d     = p_lo_q;
`endif
        wb_valid_d = 1'b0;
        wb_alu_d   = wb_alu_q;
        wb_mem_d   = wb_mem_q;
        wb_m2r_d   = wb_m2r_q;
        wb_rd_d    = wb_rd_q;
        wb_rw_d    = 1'b0;
        err_d      = err_q;
        load_done  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && !flush) begin
                    p_alu_d = in_alu_result;
                    p_rd_d  = in_rd;
                    p_rw_d  = in_reg_write;
`ifdef WB_LOAD_EXT_EN
                    p_size_d = in_mem_size;
                    p_uns_d  = in_mem_unsigned;
                    p_lo_d   = in_addr_lo;
`endif
                    if (!in_mem_to_reg) begin
                        wb_valid_d = 1'b1;
                        wb_alu_d   = in_alu_result;
                        wb_rd_d    = in_rd;
                        wb_m2r_d   = 1'b0;
                        wb_rw_d    = in_reg_write && (in_rd != '0);
                    end else if (mem_rdata_valid) begin
                        load_done = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = '0;
                    end
                end
            end
            WAIT: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (mem_rdata_valid) begin
                    load_done = 1'b1;
                    state_d   = IDLE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d    = IDLE;
                    err_d      = 1'b1;
                    wb_valid_d = 1'b1;
                    wb_alu_d   = p_alu_q;
                    wb_rd_d    = p_rd_q;
                    wb_m2r_d   = 1'b1;
                    wb_mem_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (load_done) begin
            wb_valid_d = 1'b1;
            wb_alu_d   = ld_alu;
            wb_rd_d    = ld_rd;
            wb_m2r_d   = 1'b1;
            wb_mem_d   = ld_kill ? '0 : ld_data;
            wb_rw_d    = !ld_kill && ld_rw && (ld_rd != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            p_alu_q    <= '0;
            p_rd_q     <= '0;
            p_rw_q     <= 1'b0;
`ifdef WB_LOAD_EXT_EN
            p_size_q   <= '0;
            p_uns_q    <= 1'b0;
            p_lo_q     <= '0;
`endif
            wb_valid_q <= 1'b0;
            wb_alu_q   <= '0;
            wb_mem_q   <= '0;
            wb_m2r_q   <= 1'b0;
            wb_rd_q    <= '0;
            wb_rw_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            p_alu_q    <= p_alu_d;
            p_rd_q     <= p_rd_d;
            p_rw_q     <= p_rw_d;
`ifdef WB_LOAD_EXT_EN
            p_size_q   <= p_size_d;
            p_uns_q    <= p_uns_d;
            p_lo_q     <= p_lo_d;
`endif
            wb_valid_q <= wb_valid_d;
            wb_alu_q   <= wb_alu_d;
            wb_mem_q   <= wb_mem_d;
            wb_m2r_q   <= wb_m2r_d;
            wb_rd_q    <= wb_rd_d;
            wb_rw_q    <= wb_rw_d;
            err_q      <= err_d;
        end
    end

    assign stall_up      = (state_q == WAIT);
    assign wb_valid      = wb_valid_q;
    assign wb_alu_result = wb_alu_q;
    assign wb_mem_data   = wb_mem_q;
    assign wb_mem_to_reg = wb_m2r_q;
    assign wb_rd         = wb_rd_q;
    assign wb_reg_write  = wb_rw_q;
    assign err_timeout   = err_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized transaction-level bench for mem_wb_stage with a reference model of expected write-back results.
module tb_mem_wb_stage;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_reg_write, in_mem_to_reg, flush, mem_rdata_valid;
    logic [DW-1:0] in_alu_result, mem_rdata;
    logic [AW-1:0] in_rd;
    logic [1:0]    tb_size, tb_lo;
    logic          tb_uns;
    logic          stall_up, wb_valid, wb_mem_to_reg, wb_reg_write, err_timeout;
    logic [DW-1:0] wb_alu_result, wb_mem_data;
    logic [AW-1:0] wb_rd;

    mem_wb_stage #(.DATA_W(DW), .REG_AW(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_alu_result(in_alu_result),
        .in_rd(in_rd), .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
`ifdef WB_LOAD_EXT_EN
        .in_mem_size(tb_size), .in_mem_unsigned(tb_uns), .in_addr_lo(tb_lo),
`endif
        .flush(flush), .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid),
        .stall_up(stall_up), .wb_valid(wb_valid), .wb_alu_result(wb_alu_result),
        .wb_mem_data(wb_mem_data), .wb_mem_to_reg(wb_mem_to_reg), .wb_rd(wb_rd),
        .wb_reg_write(wb_reg_write), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    logic [DW-1:0] e_alu = '0, e_mem = '0;
    logic [AW-1:0] e_rd = '0;
    logic          e_m2r = 1'b0, e_err = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected load result after optional byte/halfword selection and extension.
    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                             input logic uns, input logic [1:0] lo);
`ifdef WB_LOAD_EXT_EN
        logic [31:0] s;
        s = w >> (8 * int'(lo));
        if (sz == 2'd0) return uns ? (s & 32'hFF) : {{24{s[7]}}, s[7:0]};
        if (sz == 2'd1) return uns ? (s & 32'hFFFF) : {{16{s[15]}}, s[15:0]};
`endif
        return w;
    endfunction

    function automatic bit ref_kill(input logic [1:0] sz, input logic [1:0] lo);
`ifdef WB_LOAD_EXT_EN
        return (sz == 2'd1) && lo[0];
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk_out(input string tag, input bit v, input bit rw);
        chk({tag, ".valid"}, wb_valid, v);
        chk({tag, ".rw"}, wb_reg_write, rw);
        chk({tag, ".alu"}, wb_alu_result, e_alu);
        chk({tag, ".mem"}, wb_mem_data, e_mem);
        chk({tag, ".m2r"}, wb_mem_to_reg, e_m2r);
        chk({tag, ".rd"}, wb_rd, e_rd);
        chk({tag, ".err"}, err_timeout, e_err);
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_mem_to_reg = 0; in_reg_write = 0; flush = 0; mem_rdata_valid = 0;
        in_alu_result = $urandom; in_rd = AW'($urandom); mem_rdata = $urandom;
    endtask

    task automatic bubble(input bit stray);
        idle_inputs();
        mem_rdata_valid = stray;
        chk("bub.stall", stall_up, 0);
        tick();
        chk_out("bub", 0, 0);
    endtask

    task automatic nonload(input logic [31:0] alu, input logic [AW-1:0] rd, input bit rw, input bit fl);
        in_valid = 1; in_alu_result = alu; in_rd = rd; in_reg_write = rw; in_mem_to_reg = 0;
        flush = fl; mem_rdata_valid = 1'($urandom); mem_rdata = $urandom;
        chk("nl.stall", stall_up, 0);
        tick();
        if (!fl) begin
            e_alu = alu; e_rd = rd; e_m2r = 0;
        end
        chk_out("nl", !fl, !fl && rw && (rd != 0));
    endtask

    // lat: data arrives on that WAIT cycle (0 = same cycle, >TO = never); fl_at: flush on that WAIT cycle (0 = none).
    task automatic load(input logic [31:0] alu, input logic [AW-1:0] rd, input bit rw,
                        input int lat, input int fl_at, input logic [31:0] data,
                        input logic [1:0] sz, input logic uns, input logic [1:0] lo);
        bit kill;
        kill = ref_kill(sz, lo);
        in_valid = 1; in_alu_result = alu; in_rd = rd; in_reg_write = rw; in_mem_to_reg = 1;
        tb_size = sz; tb_uns = uns; tb_lo = lo; flush = 0;
        mem_rdata_valid = (lat == 0); mem_rdata = (lat == 0) ? data : $urandom;
        chk("ld.stall0", stall_up, 0);
        tick();
        if (lat == 0) begin
            e_alu = alu; e_rd = rd; e_m2r = 1; e_mem = kill ? 0 : ref_load(data, sz, uns, lo);
            chk_out("ld0", 1, !kill && rw && (rd != 0));
            return;
        end
        chk_out("ld.acc", 0, 0);
        for (int k = 1; k <= TO; k++) begin
            in_valid = 1'($urandom); in_mem_to_reg = 1'($urandom); in_reg_write = 1'($urandom);
            in_alu_result = $urandom; in_rd = AW'($urandom);
            tb_size = 2'($urandom); tb_uns = 1'($urandom); tb_lo = 2'($urandom);
            flush = (k == fl_at);
            mem_rdata_valid = (k == lat) || (flush && 1'($urandom));
            mem_rdata = (k == lat) ? data : $urandom;
            chk("ld.stall", stall_up, 1);
            tick();
            if (k == fl_at) begin
                chk_out("ld.flush", 0, 0);
                break;
            end else if (k == lat) begin
                e_alu = alu; e_rd = rd; e_m2r = 1; e_mem = kill ? 0 : ref_load(data, sz, uns, lo);
                chk_out("ld.data", 1, !kill && rw && (rd != 0));
                break;
            end else if (k == TO) begin
                e_alu = alu; e_rd = rd; e_m2r = 1; e_mem = 0; e_err = 1;
                chk_out("ld.tmo", 1, 0);
            end else begin
                chk_out("ld.wait", 0, 0);
            end
        end
    endtask

    initial begin
        tb_size = 2'd2; tb_uns = 0; tb_lo = 0;
        idle_inputs();
        rst_n = 0;
        tick();
        tick();
        chk_out("rst", 0, 0);
        chk("rst.stall", stall_up, 0);
        rst_n = 1;
        tick();

        nonload(32'h0000_1234, 5, 1, 0);
        chk("tp1.alu", wb_alu_result, 32'h0000_1234);
        load($urandom, 7, 1, 3, 0, 32'hDEAD_BEEF, 2'd2, 0, 0);
        chk("tp2.mem", wb_mem_data, 32'hDEAD_BEEF);
        load($urandom, 9, 1, 0, 0, 32'hA5A5_0000, 2'd2, 0, 0);
        nonload($urandom, 3, 1, 0);
        nonload($urandom, 4, 1, 0);
        load($urandom, 12, 1, 20, 0, $urandom, 2'd2, 0, 0);
        bubble(0);
        nonload($urandom, 6, 1, 0);
        load($urandom, 8, 1, 3, 2, $urandom, 2'd2, 0, 0);
        bubble(1);
        nonload($urandom, 0, 1, 0);
        nonload($urandom, 10, 1, 1);
        load($urandom, 11, 1, 5, 5, $urandom, 2'd2, 0, 0);
        load($urandom, 13, 1, 20, 15, $urandom, 2'd2, 0, 0);
        load($urandom, 14, 1, 15, 0, $urandom, 2'd2, 0, 0);
`ifdef WB_LOAD_EXT_EN
        load($urandom, 2, 1, 0, 0, 32'h0080_0000, 2'd0, 0, 2'd2);
        chk("ext.sb", wb_mem_data, 32'hFFFF_FF80);
        load($urandom, 2, 1, 2, 0, 32'h0080_0000, 2'd0, 1, 2'd2);
        chk("ext.ub", wb_mem_data, 32'h0000_0080);
        load($urandom, 2, 1, 1, 0, 32'h1234_5678, 2'd1, 0, 2'd1);
`endif

        for (int i = 0; i < 300; i++) begin
            int kind;
            logic [1:0] sz;
            kind = $urandom_range(0, 7);
`ifdef WB_LOAD_EXT_EN
            sz = 2'($urandom_range(0, 2));
`else
            sz = 2'd2;
`endif
            if (kind <= 3)
                nonload($urandom, AW'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));
            else if (kind <= 6)
                load($urandom, AW'($urandom), 1'($urandom), $urandom_range(0, 18),
                     ($urandom_range(0, 4) == 0) ? $urandom_range(1, TO) : 0,
                     $urandom, sz, 1'($urandom), 2'($urandom));
            else
                bubble(1'($urandom));
        end

        idle_inputs();
        tick();
        chk_out("end", 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline stage that directly feeds the 32-bit write-back select mux.
- Registers the ALU result, destination register and control bits, and collects load data from a variable-latency data memory.
- Outputs drive the mux: D0 = wb_alu_result, D1 = wb_mem_data, S = wb_mem_to_reg. Also drives register-file write control.
- Stalls upstream while a load is outstanding.

Parameters:
- DATA_W, 32, datapath width.
- REG_AW, 5, register address width.
- TIMEOUT, 15, maximum cycles spent in WAIT before the load is abandoned.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  MEM-stage instruction valid.
- in_alu_result  input  DATA_W  ALU result or address.
- in_rd  input  REG_AW  destination register.
- in_reg_write  input  1  instruction writes the register file.
- in_mem_to_reg  input  1  instruction is a load.
- flush  input  1  kill the current and any pending instruction.
- mem_rdata  input  DATA_W  data-memory read data.
- mem_rdata_valid  input  1  mem_rdata valid this cycle.
- stall_up  output  1  upstream must hold its inputs.
- wb_valid  output  1  write-back outputs valid this cycle.
- wb_alu_result  output  DATA_W  mux D0.
- wb_mem_data  output  DATA_W  mux D1.
- wb_mem_to_reg  output  1  mux S.
- wb_rd  output  REG_AW  register-file write address.
- wb_reg_write  output  1  register-file write enable.
- err_timeout  output  1  sticky load-timeout flag.

Behaviour:
- Reset: every output is 0. State = IDLE. Timeout counter = 0. err_timeout cleared only by reset.
- States:
  - IDLE: stall_up=0.
  - WAIT: stall_up=1, decoded combinationally from the state.
- IDLE, in_valid=1, in_mem_to_reg=0:
  - Register alu_result, rd, reg_write; wb_mem_to_reg=0.
  - wb_valid=1 the next cycle (latency 1).
- IDLE, in_valid=1, in_mem_to_reg=1:
  - Capture the fields. If mem_rdata_valid=1 in the same cycle, capture mem_rdata too and behave as a non-load (latency 1, stays IDLE).
  - Otherwise go to WAIT and clear the counter.
- WAIT:
  - Counter increments each cycle.
  - On mem_rdata_valid: register mem_rdata; next cycle wb_valid=1, wb_mem_to_reg=1; return to IDLE.
  - Upstream inputs are ignored while in WAIT.
- Timeout:
  - If the counter reaches TIMEOUT-1 without data: set err_timeout, go to IDLE.
  - Next cycle wb_valid=1 with wb_reg_write forced 0 and wb_mem_data=0.
- wb_reg_write = wb_valid & registered reg_write & (wb_rd != 0). It is never asserted when wb_valid=0.
- Hold behaviour: wb_alu_result, wb_mem_data, wb_rd and wb_mem_to_reg hold their last values when wb_valid=0. wb_valid is a single-cycle pulse per instruction.
- Flush:
  - In IDLE, the same-cycle input is dropped and wb_valid=0 next cycle.
  - In WAIT, return to IDLE and produce no wb_valid.
  - flush has priority over mem_rdata_valid and over timeout in the same cycle.
- A stray mem_rdata_valid in IDLE with no load accepted is ignored.
- Back-to-back non-loads produce one wb_valid pulse per cycle (throughput 1).

Optional Feature:
- Macro: WB_LOAD_EXT_EN.
- Defined:
  - Adds ports in_mem_size[1:0] (0=byte, 1=half, 2=word), in_mem_unsigned, in_addr_lo[1:0], registered together with the load.
  - wb_mem_data is the byte or halfword selected by addr_lo from the little-endian word, then sign- or zero-extended to DATA_W.
  - Misaligned halfword (addr_lo=1 or 3) behaves as a timeout-style kill: wb_reg_write=0 and err_timeout is not set.
- Undefined: the ports are absent and mem_rdata passes through unmodified.

Test Plan:
- Reset then non-load (alu=0x0000_1234, rd=5, reg_write=1) -> next cycle wb_valid=1, wb_alu_result=0x1234, wb_rd=5, wb_reg_write=1, wb_mem_to_reg=0.
- Load rd=7; mem_rdata_valid 3 cycles later with 0xDEAD_BEEF -> stall_up=1 for 3 cycles; then wb_valid=1, wb_mem_data=0xDEADBEEF, wb_mem_to_reg=1.
- Load with same-cycle mem_rdata_valid=1, data 0xA5A5_0000 -> no stall, result one cycle later.
- Load, no data for 15 cycles -> err_timeout=1 stays high; wb_valid pulse with wb_reg_write=0; a later non-load completes normally.
- Load, flush in 2nd WAIT cycle, data arrives next cycle -> no wb_valid, back to IDLE; a non-load with rd=0, reg_write=1 -> wb_valid=1, wb_reg_write=0.
- WB_LOAD_EXT_EN: byte signed, addr_lo=2, mem_rdata=0x0080_0000 -> wb_mem_data=0xFFFF_FF80; the same access unsigned -> 0x0000_0080.
